reduction_feeder: RTL and testbench

- Producer side of the tile reduction datapath.
- Accepts a stream of tile rows (TILE_SIZE lanes of fp16) over a valid/ready handshake.
- Packs PARALLEL_SIZE rows into one operand beat and zero-pads the final partial group.
- Drives the beat plus first/last framing to the reduction accumulator, so one reduction job covers num_rows_i rows.

---
 rtl/reduction_pkg.sv | 35 +++
 rtl/reduction_pack_buf.sv | 72 +++++++
 rtl/reduction_feeder.sv | 166 ++++++++++++++++
 tb/tb_reduction_feeder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduction_pkg.sv
// reduction_pkg
//   Types and constants shared by the tile reduction datapath: the
//   feeder (producer side) and the reduction accumulator (consumer side).
//   Contents:
//     FP16_WIDTH / FP16_ZERO     element width and the +0.0 pad value
//     fp16_t / row_t             element and default-size tile row types
//     DEFAULT_TILE_SIZE          lanes per row shared with the accumulator
//     DEFAULT_PARALLEL_SIZE      rows per operand beat shared with the accumulator
//     feeder_state_e             feeder FSM state encoding
//     slot_cnt_width()           width of a counter holding 0..parallel_size
package reduction_pkg;

  localparam int FP16_WIDTH = 16;
  localparam logic [FP16_WIDTH-1:0] FP16_ZERO = 16'h0000;

  localparam int DEFAULT_TILE_SIZE     = 129;
  localparam int DEFAULT_PARALLEL_SIZE = 3;

  typedef logic [FP16_WIDTH-1:0] fp16_t;
  typedef fp16_t [DEFAULT_TILE_SIZE-1:0] row_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  // The slot counter must hold the full count (== parallel_size), not just
  // an index, so it needs one value more than the number of slots.
  function automatic int slot_cnt_width(input int parallel_size);
    return (parallel_size < 1) ? 1 : $clog2(parallel_size + 1);
  endfunction

endpackage

// File: rtl/reduction_pack_buf.sv
// reduction_pack_buf
//   PARALLEL_SIZE-slot row register file that assembles one operand beat.
//   Rows are written one slot at a time; the beat view masks every slot at
//   or above the fill count to +0.0 so stale rows never leak into a beat.
//   Ports:
//     clk_i      clock, rising edge
//     rst_ni     asynchronous active-low reset (clears all slots)
//     wr_en_i    write row_i into slot wr_slot_i
//     wr_slot_i  target slot index
//     row_i      row data, lane i at [i*WIDTH +: WIDTH]
//     fill_i     number of valid slots exposed on operand_o
//     operand_o  packed beat, slot k at [k*TILE_SIZE*WIDTH +: TILE_SIZE*WIDTH]
module reduction_pack_buf
  import reduction_pkg::*;
#(
  parameter int TILE_SIZE     = DEFAULT_TILE_SIZE,
  parameter int PARALLEL_SIZE = DEFAULT_PARALLEL_SIZE,
  parameter int WIDTH         = FP16_WIDTH,
  parameter int SLOT_W        = slot_cnt_width(PARALLEL_SIZE)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  wr_en_i,
  input  logic [SLOT_W-1:0]                     wr_slot_i,
  input  logic [TILE_SIZE*WIDTH-1:0]            row_i,
  input  logic [SLOT_W-1:0]                     fill_i,
  output logic [PARALLEL_SIZE*TILE_SIZE*WIDTH-1:0] operand_o
);

  localparam int ROW_W = TILE_SIZE * WIDTH;
  localparam logic [ROW_W-1:0] ZERO_ROW = {TILE_SIZE{WIDTH'(FP16_ZERO)}};

  logic [ROW_W-1:0] mem_q [PARALLEL_SIZE];
  logic [ROW_W-1:0] mem_d [PARALLEL_SIZE];

  // Next-state of the slot registers: only the addressed slot takes the row.
  always_comb begin
    for (int k = 0; k < PARALLEL_SIZE; k++) begin
      if (wr_en_i && (wr_slot_i == SLOT_W'(k))) begin
        mem_d[k] = row_i;
      end else begin
        mem_d[k] = mem_q[k];
      end
    end
  end

  // Slot storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < PARALLEL_SIZE; k++) begin
        mem_q[k] <= ZERO_ROW;
      end
    end else begin
      for (int k = 0; k < PARALLEL_SIZE; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  // Beat view: slots not filled by the current group read as +0.0.
  always_comb begin
    operand_o = {(PARALLEL_SIZE*ROW_W){1'b0}};
    for (int k = 0; k < PARALLEL_SIZE; k++) begin
      if (SLOT_W'(k) < fill_i) begin
        operand_o[k*ROW_W +: ROW_W] = mem_q[k];
      end else begin
        operand_o[k*ROW_W +: ROW_W] = ZERO_ROW;
      end
    end
  end

endmodule

// File: rtl/reduction_feeder.sv
// reduction_feeder
//   Producer side of the tile reduction datapath. Accepts tile rows over a
//   valid/ready handshake, packs PARALLEL_SIZE rows per operand beat
//   (zero-padding the final partial group) and frames the beats of one job
//   with first/last for the reduction accumulator.
//   Ports:
//     CLK_i / RST_ni                  clock, async active-low reset
//     start_i, num_rows_i             job start (sampled in IDLE only), row count
//     row_valid_i, row_ready_o, row_i upstream row stream
//     operand_valid_o, operand_ready_i, operand_o, first_o, last_o
//                                     downstream beat stream and framing
//     busy_o                          job in progress
//     done_o                          one-cycle pulse at job completion
//   All outputs decode from registered state only, so they fall to zero
//   as soon as reset asserts.
module reduction_feeder
  import reduction_pkg::*;
#(
  parameter int TILE_SIZE     = DEFAULT_TILE_SIZE,
  parameter int PARALLEL_SIZE = DEFAULT_PARALLEL_SIZE,
  parameter int WIDTH         = FP16_WIDTH,
  parameter int CNT_W         = 16
) (
  input  logic                                     CLK_i,
  input  logic                                     RST_ni,
  input  logic                                     start_i,
  input  logic [CNT_W-1:0]                         num_rows_i,
  input  logic                                     row_valid_i,
  output logic                                     row_ready_o,
  input  logic [TILE_SIZE*WIDTH-1:0]               row_i,
  output logic                                     operand_valid_o,
  input  logic                                     operand_ready_i,
  output logic [PARALLEL_SIZE*TILE_SIZE*WIDTH-1:0] operand_o,
  output logic                                     first_o,
  output logic                                     last_o,
  output logic                                     busy_o,
  output logic                                     done_o
);

  localparam int SLOT_W = slot_cnt_width(PARALLEL_SIZE);

  feeder_state_e     state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              first_pending_q, first_pending_d;

  logic              wr_en_s;
  logic [SLOT_W-1:0] slot_inc_s;
  logic [SLOT_W-1:0] fill_cnt_s;
  logic              rows_left_s;
  logic              row_hs_s;

  // Next-state, counters and output decode.
  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    slot_d          = slot_q;
    first_pending_d = first_pending_q;
    wr_en_s         = 1'b0;
    fill_cnt_s      = SLOT_W'(0);
    row_ready_o     = 1'b0;
    operand_valid_o = 1'b0;
    first_o         = 1'b0;
    last_o          = 1'b0;
    done_o          = 1'b0;
    busy_o          = (state_q != ST_IDLE);
    slot_inc_s      = slot_q + SLOT_W'(1);
    rows_left_s     = (rem_q != CNT_W'(0));
    row_hs_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d           = num_rows_i;
          slot_d          = SLOT_W'(0);
          first_pending_d = 1'b1;
          if (num_rows_i == CNT_W'(0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FILL: begin
        // Ready is gated by rem so rem can never wrap below zero.
        row_ready_o = rows_left_s;
        row_hs_s    = row_valid_i && rows_left_s;
        if (row_hs_s) begin
          wr_en_s = 1'b1;
          slot_d  = slot_inc_s;
          rem_d   = rem_q - CNT_W'(1);
          if ((slot_inc_s == SLOT_W'(PARALLEL_SIZE)) || (rem_q == CNT_W'(1))) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end

      ST_ISSUE: begin
        // Beat and framing come straight from registers, so they hold
        // steady for as long as the accumulator stalls.
        operand_valid_o = 1'b1;
        fill_cnt_s      = slot_q;
        first_o         = first_pending_q;
        last_o          = !rows_left_s;
        if (operand_ready_i) begin
          first_pending_d = 1'b0;
          slot_d          = SLOT_W'(0);
          if (rows_left_s) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and job counters.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      state_q         <= ST_IDLE;
      rem_q           <= CNT_W'(0);
      slot_q          <= SLOT_W'(0);
      first_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      slot_q          <= slot_d;
      first_pending_q <= first_pending_d;
    end
  end

  reduction_pack_buf #(
    .TILE_SIZE     (TILE_SIZE),
    .PARALLEL_SIZE (PARALLEL_SIZE),
    .WIDTH         (WIDTH),
    .SLOT_W        (SLOT_W)
  ) u_pack_buf (
    .clk_i     (CLK_i),
    .rst_ni    (RST_ni),
    .wr_en_i   (wr_en_s),
    .wr_slot_i (slot_q),
    .row_i     (row_i),
    .fill_i    (fill_cnt_s),
    .operand_o (operand_o)
  );

endmodule

// File: tb/tb_reduction_feeder.sv
// tb_reduction_feeder
//   Directed bench for reduction_feeder. Expected beats are pushed to a
//   scoreboard when a job is launched and popped by a monitor whenever a
//   beat handshake occurs. Inputs change 1 time unit after the rising edge,
//   outputs are sampled on the falling edge.
module tb_reduction_feeder;

  localparam int TILE  = 129;
  localparam int P     = 3;
  localparam int W     = 16;
  localparam int CNT_W = 16;
  localparam int ROW_W = TILE * W;
  localparam int OP_W  = P * ROW_W;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [CNT_W-1:0] num_rows_i;
  logic             row_valid_i;
  logic             row_ready_o;
  logic [ROW_W-1:0] row_i;
  logic             operand_valid_o;
  logic             operand_ready_i;
  logic [OP_W-1:0]  operand_o;
  logic             first_o;
  logic             last_o;
  logic             busy_o;
  logic             done_o;

  typedef struct {
    logic [OP_W-1:0] data;
    logic            first;
    logic            last;
  } beat_t;

  beat_t           sb[$];
  beat_t           mon_e;
  int              n_cmp    = 0;
  int              n_err    = 0;
  int              done_cnt = 0;
  logic [OP_W-1:0] zero_beat = '0;

  reduction_feeder #(
    .TILE_SIZE     (TILE),
    .PARALLEL_SIZE (P),
    .WIDTH         (W),
    .CNT_W         (CNT_W)
  ) dut (
    .CLK_i           (clk),
    .RST_ni          (rst_n),
    .start_i         (start_i),
    .num_rows_i      (num_rows_i),
    .row_valid_i     (row_valid_i),
    .row_ready_o     (row_ready_o),
    .row_i           (row_i),
    .operand_valid_o (operand_valid_o),
    .operand_ready_i (operand_ready_i),
    .operand_o       (operand_o),
    .first_o         (first_o),
    .last_o          (last_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_diff(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    for (int i = 0; i < P * TILE; i++) begin
      if (a[i*W +: W] !== b[i*W +: W]) return i;
    end
    return 0;
  endfunction

  task automatic chk_beat(input string tag, input logic [OP_W-1:0] obs, input logic [OP_W-1:0] exp);
    int d;
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      d = first_diff(obs, exp);
      $error("FAIL %s: slot %0d lane %0d observed %h expected %h",
             tag, d / TILE, d % TILE, obs[d*W +: W], exp[d*W +: W]);
    end
  endtask

  // tag 0: every lane of row j holds j+1; otherwise lanes are distinct.
  function automatic logic [ROW_W-1:0] make_row(input int j, input int tag);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < TILE; i++) begin
      if (tag == 0) r[i*W +: W] = 16'(j + 1);
      else          r[i*W +: W] = 16'((((tag * 8) + j) << 8) | i);
    end
    return r;
  endfunction

  task automatic push_expected(input int n, input int tag);
    beat_t b;
    int    nb;
    nb = (n + P - 1) / P;
    for (int bi = 0; bi < nb; bi++) begin
      b.data = '0;
      for (int k = 0; k < P; k++) begin
        if (bi * P + k < n) b.data[k*ROW_W +: ROW_W] = make_row(bi * P + k, tag);
      end
      b.first = (bi == 0);
      b.last  = (bi == nb - 1);
      sb.push_back(b);
    end
  endtask

  task automatic start_job(input int n);
    start_i    = 1'b1;
    num_rows_i = CNT_W'(n);
    @(posedge clk); #1;
    start_i    = 1'b0;
  endtask

  task automatic send_row(input logic [ROW_W-1:0] r);
    int   n;
    logic hs;
    row_valid_i = 1'b1;
    row_i       = r;
    n           = 0;
    do begin
      @(negedge clk);
      hs = row_ready_o;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 200);
    row_valid_i = 1'b0;
    n_cmp++;
    assert (hs) else begin
      n_err++;
      $error("FAIL row_handshake_timeout: observed no ready expected ready within 200 cycles");
    end
  endtask

  task automatic send_rows(input int n, input int tag);
    for (int j = 0; j < n; j++) send_row(make_row(j, tag));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    assert (n < 500) else begin
      n_err++;
      $error("FAIL idle_timeout: observed busy expected idle within 500 cycles");
    end
  endtask

  task automatic run_job(input int n, input int tag);
    int d0;
    d0 = done_cnt;
    push_expected(n, tag);
    start_job(n);
    send_rows(n, tag);
    wait_idle();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
  endtask

  // Monitor: count done pulses and score every accepted beat.
  always @(negedge clk) begin
    if (done_o === 1'b1) done_cnt++;
    if (operand_valid_o === 1'b1 && operand_ready_i === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_beat: observed beat expected none");
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk_beat("beat_data", operand_o, mon_e.data);
        chk("beat_first", 64'(first_o), 64'(mon_e.first));
        chk("beat_last", 64'(last_o), 64'(mon_e.last));
      end
    end
  end

  initial begin
    int d0;
    rst_n           = 1'b0;
    start_i         = 1'b0;
    num_rows_i      = '0;
    row_valid_i     = 1'b0;
    row_i           = '0;
    operand_ready_i = 1'b1;

    // Reset state.
    #2;
    chk("rst_row_ready", 64'(row_ready_o), 64'd0);
    chk("rst_valid", 64'(operand_valid_o), 64'd0);
    chk_beat("rst_operand", operand_o, zero_beat);
    chk("rst_first", 64'(first_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // N=6: two full beats.
    run_job(6, 0);

    // N=4: partial last beat; previous job left r3..r5 in the buffer.
    run_job(4, 1);

    // N=0: straight to DONE, no beat.
    d0 = done_cnt;
    start_i    = 1'b1;
    num_rows_i = '0;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("n0_busy_done_state", 64'(busy_o), 64'd1);
    chk("n0_done_pulse", 64'(done_o), 64'd1);
    chk("n0_no_valid", 64'(operand_valid_o), 64'd0);
    @(posedge clk); #1;
    chk("n0_busy_after", 64'(busy_o), 64'd0);
    chk("n0_done_after", 64'(done_o), 64'd0);
    chk("n0_done_count", 64'(done_cnt - d0), 64'd1);

    // N=3 with 5 stall cycles; rows offered during the stall must be refused.
    d0 = done_cnt;
    operand_ready_i = 1'b0;
    push_expected(3, 2);
    start_job(3);
    send_rows(3, 2);
    row_valid_i = 1'b1;
    row_i       = make_row(7, 9);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", 64'(operand_valid_o), 64'd1);
      chk_beat("stall_hold", operand_o, sb[0].data);
      chk("stall_first", 64'(first_o), 64'd1);
      chk("stall_last", 64'(last_o), 64'd1);
      chk("stall_row_ready", 64'(row_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    operand_ready_i = 1'b1;
    row_valid_i     = 1'b0;
    wait_idle();
    chk("stall_sb_drained", 64'(sb.size()), 64'd0);
    chk("stall_done_count", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of an N=6 job.
    d0 = done_cnt;
    push_expected(6, 5);
    start_job(6);
    send_row(make_row(0, 5));
    send_row(make_row(1, 5));
    chk("mid_pre_row_ready", 64'(row_ready_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_row_ready", 64'(row_ready_o), 64'd0);
    chk("mid_rst_valid", 64'(operand_valid_o), 64'd0);
    chk_beat("mid_rst_operand", operand_o, zero_beat);
    chk("mid_rst_first", 64'(first_o), 64'd0);
    chk("mid_rst_last", 64'(last_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_done", 64'(done_o), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    run_job(3, 6);

    // start_i with num_rows_i=9 while busy on an N=3 job is ignored.
    d0 = done_cnt;
    push_expected(3, 4);
    start_job(3);
    start_i    = 1'b1;
    num_rows_i = CNT_W'(9);
    @(posedge clk); #1;
    start_i = 1'b0;
    send_rows(3, 4);
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    chk("ign_sb_drained", 64'(sb.size()), 64'd0);
    chk("ign_done_count", 64'(done_cnt - d0), 64'd1);
    chk("ign_busy_after", 64'(busy_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
